compute_unit_pipe: RTL and testbench
====================================

Name: compute_unit_pipe

Overview:
Parametrised, pipelined successor of the PE compute unit. It processes LANES independent signed lanes per beat, using valid/ready handshakes on both the input and output side. Supported ops: SUB, CMP, ADD, MUL (optional Q-format dequant shift with saturation), MAX, and multi-beat MAC with per-lane accumulators. It sits inside the PE between the operand/weight fetch and the PE result buffer.

Parameters:
DATA_W, 32, lane operand/result width (signed two's complement)
FRAC_W, 16, fractional bits removed by the dequant shift
LANES, 4, number of parallel lanes
ACC_W, 72, per-lane MAC accumulator width (must be at least 2*DATA_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_a  in  LANES*DATA_W  operand A, lane i at [i*DATA_W +: DATA_W]
in_b  in  LANES*DATA_W  operand B (weight/parameter)
in_sel  in  3  op: 000 SUB, 001 CMP, 010 ADD, 011 MUL, 100 MAC, 101 MAX, 11x reserved
in_shift  in  1  dequant enable: arithmetic shift right by FRAC_W, then saturate
in_last  in  1  MAC only: final beat of the accumulation; ignored for other ops
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  LANES*DATA_W  result lanes
out_sat  out  LANES  per-lane flag: saturation occurred in this result

Behaviour:
- Reset (async, rst=1):
  - Stage valids, out_valid, out_data, out_sat and all accumulators go to 0.
  - in_ready=1 combinationally once valids are 0.
  - An in-flight MAC sequence is discarded; the next MAC starts from 0.
- Pipeline, two register stages:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - All stages move only on advance.
  - S1 registers the operands, op, shift and last, plus the full 2*DATA_W signed product per lane.
  - S2 applies shift/saturate/accumulate and drives out_*.
- Latency: a beat accepted at edge N presents its result at out_valid after edge N+2 when there is no stall.
  - Back-to-back throughput is 1 beat/cycle.
  - Under stall, out_data/out_sat hold stable while out_valid=1 && !out_ready.
  - No beat is lost or reordered.
- Arithmetic per lane (signed):
  - SUB: a-b, wraps to DATA_W. ADD: a+b, wraps. Both set sat=0.
  - CMP: 1 if a>b signed, else 0.
  - MAX: signed max(a,b).
  - MUL, in_shift=0: low DATA_W bits of the product, sat=0.
  - MUL, in_shift=1: product >>> FRAC_W, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat=1 if clamped.
  - Reserved ops: result 0, sat=0, beat still emitted.
- MAC:
  - acc_next = acc + sign-extended full product; wraps at ACC_W.
  - Non-last MAC beats update acc at the S2 advance and emit no output beat (out_valid stays 0 for them).
  - Last beat: the result is sat(acc_next), or sat(acc_next >>> FRAC_W) if in_shift. This clamp sets sat. The beat is emitted and acc is cleared to 0 in the same cycle.
  - Non-MAC beats interleaved inside a MAC sequence leave acc untouched.
  - Back-to-back MAC sequences need no idle cycle.
- Simultaneous accept and drain in one cycle is legal; the pipeline stays full.

Test Plan:
1. Reset check. Assert rst mid-stream. Required: out_valid=0, out_data=0, out_sat=0, in_ready=1 while rst=1 and after release.
2. MUL dequant, all lanes: a=0x00030000, b=0xFFFE0000, in_shift=1, sel=011. Required: out 0xFFFA0000, sat=0, exactly 2 cycles after accept. Same operands with in_shift=0 give out 0x00000000.
3. Saturation: a=b=0x7FFF0000, MUL, in_shift=1. Required: out 0x7FFFFFFF, sat=1. Then a=0x7FFF0000, b=0x80000000. Required: out 0x80000000, sat=1.
4. MAC: 4 beats of a=0x00010000, b=0x00020000, in_shift=1, in_last on beat 4. Required: exactly one output beat, 0x00080000 per lane. An immediate second identical sequence yields 0x00080000 again (acc was cleared).
5. Backpressure: 10 continuous ADD beats (a=k, b=1, k=0..9) with out_ready low for cycles 3-7. Required: in_ready drops while out_valid held and stalled; results are 1..10, in order, none duplicated; out_data stable during the stall.
6. Mixed ops: CMP a=0xFFFFFFFF, b=0x00000001 gives 0; MAX gives 0x00000001; SUB 0 - 1 gives 0xFFFFFFFF. Reset asserted after 2 of 4 MAC beats, then a fresh 1-beat MAC with last and a=b=0x00010000, in_shift=1, gives 0x00010000.

Source files
------------

// File: rtl/compute_unit_pipe.sv
// Two-stage pipelined multi-lane compute unit for the PE.
// S1 registers operands, op controls and the full-width per-lane product.
// S2 applies wrap/shift/saturate or MAC accumulation and drives out_*.
module compute_unit_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 72
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic [2:0]              in_sel,
  input  logic                    in_shift,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [2:0] OpSub = 3'b000;
  localparam logic [2:0] OpCmp = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpMul = 3'b011;
  localparam logic [2:0] OpMac = 3'b100;
  localparam logic [2:0] OpMax = 3'b101;

  localparam logic [DATA_W-1:0] MaxVal = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

  logic                    advance;
  logic                    s1_valid;
  logic [LANES*DATA_W-1:0] s1_a;
  logic [LANES*DATA_W-1:0] s1_b;
  logic [2:0]              s1_sel;
  logic                    s1_shift;
  logic                    s1_last;
  logic                    mac_beat;
  logic                    emit;
  logic [LANES*DATA_W-1:0] res;
  logic [LANES-1:0]        res_sat;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign mac_beat = s1_valid && (s1_sel == OpMac);
  // Non-last MAC beats only update the accumulator and produce no output beat.
  assign emit     = s1_valid && ((s1_sel != OpMac) || s1_last);

  // S1: capture operands and controls of the accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= '0;
      s1_shift <= 1'b0;
      s1_last  <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_sel   <= in_sel;
      s1_shift <= in_shift;
      s1_last  <= in_last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gen_lane
    logic signed [DATA_W-1:0] ia;
    logic signed [DATA_W-1:0] ib;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_sh;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_fin;
    logic                     prod_sat;
    logic                     acc_sat;
    logic [DATA_W-1:0]        prod_clamp;
    logic [DATA_W-1:0]        acc_clamp;
    logic [DATA_W-1:0]        lane_res;
    logic                     lane_sat;

    assign ia = in_a[i*DATA_W +: DATA_W];
    assign ib = in_b[i*DATA_W +: DATA_W];
    assign a  = s1_a[i*DATA_W +: DATA_W];
    assign b  = s1_b[i*DATA_W +: DATA_W];

    // S1 product register: full signed 2*DATA_W product of the incoming lane.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
      end else if (advance) begin
        prod_q <= PROD_W'(ia) * PROD_W'(ib);
      end
    end

    // Dequantised product: in range only if all bits above the result MSB match it.
    assign prod_sh    = prod_q >>> FRAC_W;
    assign prod_sat   = !((&prod_sh[PROD_W-1:DATA_W-1]) || !(|prod_sh[PROD_W-1:DATA_W-1]));
    assign prod_clamp = prod_sat ? (prod_sh[PROD_W-1] ? MinVal : MaxVal)
                                 : prod_sh[DATA_W-1:0];

    assign acc_sum   = acc_q + ACC_W'(prod_q);
    assign acc_fin   = s1_shift ? (acc_sum >>> FRAC_W) : acc_sum;
    assign acc_sat   = !((&acc_fin[ACC_W-1:DATA_W-1]) || !(|acc_fin[ACC_W-1:DATA_W-1]));
    assign acc_clamp = acc_sat ? (acc_fin[ACC_W-1] ? MinVal : MaxVal)
                               : acc_fin[DATA_W-1:0];

    // Accumulator: adds on every MAC beat leaving S2, cleared by the last beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (advance && mac_beat) begin
        acc_q <= s1_last ? '0 : acc_sum;
      end
    end

    // S2 lane result selection.
    always_comb begin
      lane_res = '0;
      lane_sat = 1'b0;
      case (s1_sel)
        OpSub: lane_res = a - b;
        OpCmp: lane_res = {{(DATA_W-1){1'b0}}, (a > b)};
        OpAdd: lane_res = a + b;
        OpMul: begin
          if (s1_shift) begin
            lane_res = prod_clamp;
            lane_sat = prod_sat;
          end else begin
            lane_res = prod_q[DATA_W-1:0];
          end
        end
        OpMac: begin
          lane_res = acc_clamp;
          lane_sat = acc_sat;
        end
        OpMax:   lane_res = (a > b) ? a : b;
        default: lane_res = '0;
      endcase
    end

    assign res[i*DATA_W +: DATA_W] = lane_res;
    assign res_sat[i]              = lane_sat;
  end

  // S2 output register; data holds while stalled or while no beat is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (advance) begin
      out_valid <= emit;
      if (emit) begin
        out_data <= res;
        out_sat  <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Scoreboard bench for compute_unit_pipe: stimulus pushes expected beats from a
// behavioural lane model; a monitor pops and compares on every output transfer.
module tb_compute_unit_pipe;

  localparam int W = 32;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L*W-1:0] in_a = '0;
  logic [L*W-1:0] in_b = '0;
  logic [2:0]     in_sel = '0;
  logic           in_shift = 1'b0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_sat;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_mode = 0;
  int stall_base = 0;

  typedef struct {
    logic [L*W-1:0] d;
    logic [L-1:0]   s;
    int             acyc;
    bit             chk;
  } exp_t;

  exp_t sb[$];
  logic signed [71:0] macc [L];

  compute_unit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .in_shift  (in_shift),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [L*W-1:0] rep(input logic [W-1:0] x);
    return {L{x}};
  endfunction

  // Clamp a wide signed value to the 32-bit range; returns {sat, value}.
  function automatic logic [32:0] clamp(input logic signed [71:0] v);
    logic signed [71:0] hi;
    logic signed [71:0] lo;
    hi = 72'sd2147483647;
    lo = -72'sd2147483648;
    if (v > hi) return {1'b1, 32'h7FFF_FFFF};
    if (v < lo) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  function automatic void model_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                     input logic [2:0] sel, input logic sh, input logic lst,
                                     input int acyc, input bit chk);
    exp_t e;
    bit emit;
    logic signed [31:0] sa;
    logic signed [31:0] sbv;
    longint p;
    logic signed [71:0] v;
    logic [32:0] c;
    emit = 1'b1;
    e.d = '0;
    e.s = '0;
    e.acyc = acyc;
    e.chk = chk;
    for (int i = 0; i < L; i++) begin
      sa  = a[i*W +: W];
      sbv = b[i*W +: W];
      p   = sa * sbv;
      v   = 72'(p);
      case (sel)
        3'd0: e.d[i*W +: W] = sa - sbv;
        3'd1: e.d[i*W +: W] = (sa > sbv) ? 32'd1 : 32'd0;
        3'd2: e.d[i*W +: W] = sa + sbv;
        3'd3: begin
          if (sh) begin
            c = clamp(v >>> 16);
            e.d[i*W +: W] = c[31:0];
            e.s[i] = c[32];
          end else begin
            e.d[i*W +: W] = p[31:0];
          end
        end
        3'd4: begin
          macc[i] = macc[i] + v;
          if (lst) begin
            c = clamp(sh ? (macc[i] >>> 16) : macc[i]);
            e.d[i*W +: W] = c[31:0];
            e.s[i] = c[32];
            macc[i] = '0;
          end else begin
            emit = 1'b0;
          end
        end
        3'd5: e.d[i*W +: W] = (sa > sbv) ? sa : sbv;
        default: e.d[i*W +: W] = '0;
      endcase
    end
    if (emit) sb.push_back(e);
  endfunction

  // Present one beat (called shortly after a rising edge) and hold it until accepted.
  task automatic send(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic [2:0] sel,
                      input logic sh, input logic lst, input bit chk);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sel = sel;
    in_shift = sh;
    in_last = lst;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end else begin
      model_beat(a, b, sel, sh, lst, cyc, chk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s got v=%b d=%h s=%b rdy=%b required v=0 d=0 s=0 rdy=1",
               name, out_valid, out_data, out_sat, in_ready);
    end
  endtask

  task automatic flush_model();
    sb.delete();
    for (int i = 0; i < L; i++) macc[i] = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required=0", name, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (out_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = !((cyc - stall_base) >= 3 && (cyc - stall_base) <= 7);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every output transfer and checks stall behaviour.
  initial begin
    exp_t e;
    bit was_stall;
    logic [L*W-1:0] held_d;
    logic [L-1:0] held_s;
    was_stall = 1'b0;
    held_d = '0;
    held_s = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        was_stall = 1'b0;
      end else begin
        if (out_valid && !out_ready) begin
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready got=%b required=0", in_ready);
          end
          if (was_stall) begin
            checks++;
            if (out_data !== held_d || out_sat !== held_s) begin
              failures++;
              $display("FAIL stall_hold got=%h/%b required=%h/%b", out_data, out_sat,
                       held_d, held_s);
            end
          end
          held_d = out_data;
          held_s = out_sat;
          was_stall = 1'b1;
        end else begin
          was_stall = 1'b0;
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat got=%h required=no beat", out_data);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_sat !== e.s) begin
              failures++;
              $display("FAIL result got=%h sat=%b required=%h sat=%b", out_data, out_sat,
                       e.d, e.s);
            end
            if (e.chk) begin
              checks++;
              // Handshake seen in the cycle after edge N; result must follow edge N+2.
              if (cyc - e.acyc != 2) begin
                failures++;
                $display("FAIL latency got=%0d required=2", cyc - e.acyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    logic [L*W-1:0] ra;
    logic [L*W-1:0] rb;
    logic [2:0] rsel;
    flush_model();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_hold");
    rst = 1'b0;
    #1;
    check_reset("reset_release");
    @(posedge clk);
    #1;

    // MUL dequant, with and without shift.
    send(rep(32'h0003_0000), rep(32'hFFFE_0000), 3'b011, 1'b1, 1'b0, 1'b1);
    send(rep(32'h0003_0000), rep(32'hFFFE_0000), 3'b011, 1'b0, 1'b0, 1'b1);
    // Saturation in both directions.
    send(rep(32'h7FFF_0000), rep(32'h7FFF_0000), 3'b011, 1'b1, 1'b0, 1'b0);
    send(rep(32'h7FFF_0000), rep(32'h8000_0000), 3'b011, 1'b1, 1'b0, 1'b0);
    wait_drain("drain_mul");

    // Two back-to-back 4-beat MAC sequences.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        send(rep(32'h0001_0000), rep(32'h0002_0000), 3'b100, 1'b1, (k == 3), 1'b0);
      end
    end
    wait_drain("drain_mac");

    // Reset mid-stream with beats in flight.
    send(rep(32'h0000_0005), rep(32'h0000_0007), 3'b011, 1'b0, 1'b0, 1'b0);
    send(rep(32'h0000_0009), rep(32'h0000_0003), 3'b010, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("reset_mid_stream");
    flush_model();
    @(posedge clk);
    #1;
    check_reset("reset_mid_hold");
    rst = 1'b0;
    #1;
    check_reset("reset_mid_release");
    @(posedge clk);
    #1;

    // Backpressure: 10 ADD beats with a stall window.
    stall_base = cyc;
    out_mode = 2;
    for (int k = 0; k < 10; k++) begin
      send(rep(32'(k)), rep(32'd1), 3'b010, 1'b0, 1'b0, 1'b0);
    end
    wait_drain("drain_stall");
    out_mode = 0;

    // Mixed ops.
    send(rep(32'hFFFF_FFFF), rep(32'h0000_0001), 3'b001, 1'b0, 1'b0, 1'b0);
    send(rep(32'hFFFF_FFFF), rep(32'h0000_0001), 3'b101, 1'b0, 1'b0, 1'b0);
    send(rep(32'h0000_0000), rep(32'h0000_0001), 3'b000, 1'b0, 1'b0, 1'b0);
    send(rep(32'h1234_5678), rep(32'h0000_0001), 3'b110, 1'b0, 1'b0, 1'b0);
    wait_drain("drain_mixed");

    // Reset after 2 of 4 MAC beats, then a fresh single-beat MAC.
    send(rep(32'h0001_0000), rep(32'h0002_0000), 3'b100, 1'b1, 1'b0, 1'b0);
    send(rep(32'h0001_0000), rep(32'h0002_0000), 3'b100, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(rep(32'h0001_0000), rep(32'h0001_0000), 3'b100, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_mac_after_reset");

    // Randomised traffic with random backpressure and idle gaps.
    out_mode = 1;
    for (int k = 0; k < 300; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0) begin
        ra = ra >> $urandom_range(8, 24);
        rb = rb >> $urandom_range(8, 24);
      end
      rsel = 3'($urandom_range(0, 7));
      send(ra, rb, rsel, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'b0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    send(rep(32'h0000_0100), rep(32'h0000_0100), 3'b100, 1'b0, 1'b1, 1'b0);
    wait_drain("drain_random");
    out_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
